// File: rtl/histogram_sequencer.sv
// -----------------------------------------------------------------------------
// histogram_sequencer
//
// Frame-level controller for the x/y projection-histogram engine. It takes a
// raster stream of binary pixels, drives the engine through
// COMPUTE -> READ -> CLEAR, and streams the bins back out of it. From those
// bins it derives the x and y medians of the foreground pixels, which give the
// object centre for the median-filter path. This block is the only master of
// the engine's control inputs.
//
// Ports
//   clk                         rising-edge clock
//   reset                       synchronous, active-low reset
//   frameStart                  1-cycle pulse: process the next frame
//   pixValid / pixData          pixel beat and its value (1 = foreground)
//   pixReady                    beat accepted when pixValid & pixReady
//   hStart/hStop/hRead/hClear   1-cycle request pulses to the engine
//   hXAddress/hYAddress/hPixel  engine accumulate address and increment
//   hXData/hXValid              x bin read-back stream (bins 0,1,2.. in order)
//   hYData/hYValid              y bin read-back stream (bins 0,1,2.. in order)
//   hReady                      engine idle
//   xMedian/yMedian             median bins of the last frame
//   pixelCount                  foreground pixels of the last frame (saturating)
//   empty                       last frame had no foreground pixel
//   resultValid                 1-cycle pulse: result outputs updated
//   busy                        high in every state except IDLE
// -----------------------------------------------------------------------------
module histogram_sequencer #(
    parameter int IMWIDTH  = 240,
    parameter int IMHEIGHT = 180,
    parameter int GUARD    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frameStart,
    input  logic        pixValid,
    input  logic        pixData,
    output logic        pixReady,
    output logic        hStart,
    output logic        hStop,
    output logic        hRead,
    output logic        hClear,
    output logic [7:0]  hXAddress,
    output logic [7:0]  hYAddress,
    output logic        hPixel,
    input  logic [7:0]  hXData,
    input  logic [7:0]  hYData,
    input  logic        hXValid,
    input  logic        hYValid,
    input  logic        hReady,
    output logic [7:0]  xMedian,
    output logic [7:0]  yMedian,
    output logic [15:0] pixelCount,
    output logic        empty,
    output logic        resultValid,
    output logic        busy
);

    typedef enum logic [2:0] {
        INIT_CLR, IDLE, START, SCAN, STOP, READ, CLEAR, DONE
    } state_t;

    localparam int          GUARD_W = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    localparam logic [7:0]  X_LAST  = 8'(IMWIDTH - 1);
    localparam logic [7:0]  Y_LAST  = 8'(IMHEIGHT - 1);

    // Sequencing state
    state_t               state_q, state_d;
    logic                 sent_q, sent_d;     // request pulse already issued in this state
    logic [GUARD_W-1:0]   guard_q, guard_d;   // cycles left during which hReady is stale

    // Raster position and per-frame accumulators
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [15:0] acc_count_q, acc_count_d;
    logic [15:0] sx_q, sx_d, sy_q, sy_d;
    logic [7:0]  xi_q, xi_d, yi_q, yi_d;      // index of the next bin to arrive
    logic        x_hit_q, x_hit_d, y_hit_q, y_hit_d;
    logic [7:0]  x_cand_q, x_cand_d, y_cand_q, y_cand_d;

    // Registered outputs
    logic        pix_ready_q, pix_ready_d;
    logic        h_start_q, h_start_d, h_stop_q, h_stop_d;
    logic        h_read_q, h_read_d, h_clear_q, h_clear_d;
    logic [7:0]  h_x_address_q, h_x_address_d, h_y_address_q, h_y_address_d;
    logic        h_pixel_q, h_pixel_d;
    logic [7:0]  x_median_q, x_median_d, y_median_q, y_median_d;
    logic [15:0] pixel_count_q, pixel_count_d;
    logic        empty_q, empty_d;
    logic        result_valid_q, result_valid_d;
    logic        busy_q, busy_d;

    // Combinational helpers
    logic        req_state, req_issue, req_done;
    logic        accept, last_beat;
    logic [15:0] sum_x, sum_y;
    logic        x_hit_now, y_hit_now;

    always_comb begin
        // NOTE: every target gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d        = state_q;
        sent_d         = sent_q;
        guard_d        = guard_q;
        x_d            = x_q;
        y_d            = y_q;
        acc_count_d    = acc_count_q;
        sx_d           = sx_q;
        sy_d           = sy_q;
        xi_d           = xi_q;
        yi_d           = yi_q;
        x_hit_d        = x_hit_q;
        y_hit_d        = y_hit_q;
        x_cand_d       = x_cand_q;
        y_cand_d       = y_cand_q;
        h_x_address_d  = h_x_address_q;
        h_y_address_d  = h_y_address_q;
        x_median_d     = x_median_q;
        y_median_d     = y_median_q;
        pixel_count_d  = pixel_count_q;
        empty_d        = empty_q;
        h_start_d      = 1'b0;
        h_stop_d       = 1'b0;
        h_read_d       = 1'b0;
        h_clear_d      = 1'b0;
        h_pixel_d      = 1'b0;   // the engine accumulates every COMPUTE cycle
        result_valid_d = 1'b0;
        req_done       = 1'b0;

        accept    = pix_ready_q & pixValid;
        last_beat = (x_q == X_LAST) && (y_q == Y_LAST);
        sum_x     = sx_q + 16'(hXData);
        sum_y     = sy_q + 16'(hYData);
        // 2*sum >= count, evaluated at 17 bits so the doubling cannot wrap
        x_hit_now = {sum_x, 1'b0} >= {1'b0, acc_count_q};
        y_hit_now = {sum_y, 1'b0} >= {1'b0, acc_count_q};

        // Shared request handshake: pulse once, ignore hReady for GUARD
        // cycles after the pulse, then wait for the engine to go idle.
        req_state = (state_q == INIT_CLR) || (state_q == STOP) ||
                    (state_q == READ)     || (state_q == CLEAR);
        req_issue = req_state && !sent_q;
        if (req_state) begin
            if (!sent_q) begin
                sent_d  = 1'b1;
                guard_d = GUARD_W'(GUARD);
            end else if (guard_q != '0) begin
                guard_d = guard_q - 1'b1;
            end else if (hReady) begin
                req_done = 1'b1;
                sent_d   = 1'b0;
            end
        end

        case (state_q)
            INIT_CLR: begin
                h_clear_d = req_issue;
                if (req_done) state_d = IDLE;
            end
            IDLE: begin
                if (frameStart && hReady) begin
                    state_d     = START;
                    x_d         = '0;
                    y_d         = '0;
                    acc_count_d = '0;
                    sx_d        = '0;
                    sy_d        = '0;
                    xi_d        = '0;
                    yi_d        = '0;
                    x_hit_d     = 1'b0;
                    y_hit_d     = 1'b0;
                    x_cand_d    = '0;
                    y_cand_d    = '0;
                end
            end
            START: begin
                // The engine holds COMPUTE until hStop, so no ready wait here.
                h_start_d = 1'b1;
                state_d   = SCAN;
            end
            SCAN: begin
                if (accept) begin
                    h_x_address_d = x_q;
                    h_y_address_d = y_q;
                    h_pixel_d     = pixData;
                    if (pixData && (acc_count_q != 16'hFFFF))
                        acc_count_d = acc_count_q + 16'd1;
                    if (last_beat) begin
                        state_d = STOP;
                    end else if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 8'd1;
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                end
            end
            STOP: begin
                h_stop_d = req_issue;
                if (req_done) state_d = READ;
            end
            READ: begin
                h_read_d = req_issue;
                // Until the first hit the candidate tracks the latest bin, so
                // a frame whose sums never reach half the count (engine bin
                // wrap) reports the last bin received.
                if (hXValid) begin
                    sx_d = sum_x;
                    xi_d = xi_q + 8'd1;
                    if (!x_hit_q) begin
                        x_cand_d = xi_q;
                        x_hit_d  = x_hit_now;
                    end
                end
                if (hYValid) begin
                    sy_d = sum_y;
                    yi_d = yi_q + 8'd1;
                    if (!y_hit_q) begin
                        y_cand_d = yi_q;
                        y_hit_d  = y_hit_now;
                    end
                end
                if (req_done) state_d = CLEAR;
            end
            CLEAR: begin
                h_clear_d = req_issue;
                if (req_done) begin
                    // Results load on the way into DONE so they are valid
                    // in the same cycle as the resultValid pulse.
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                    pixel_count_d  = acc_count_q;
                    empty_d        = (acc_count_q == 16'd0);
                    x_median_d     = (acc_count_q == 16'd0) ? 8'd0 : x_cand_q;
                    y_median_d     = (acc_count_q == 16'd0) ? 8'd0 : y_cand_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT_CLR;
            end
        endcase

        pix_ready_d = (state_d == SCAN);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: registers update with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q        <= INIT_CLR;
            sent_q         <= 1'b0;
            guard_q        <= '0;
            x_q            <= '0;
            y_q            <= '0;
            acc_count_q    <= '0;
            sx_q           <= '0;
            sy_q           <= '0;
            xi_q           <= '0;
            yi_q           <= '0;
            x_hit_q        <= 1'b0;
            y_hit_q        <= 1'b0;
            x_cand_q       <= '0;
            y_cand_q       <= '0;
            pix_ready_q    <= 1'b0;
            h_start_q      <= 1'b0;
            h_stop_q       <= 1'b0;
            h_read_q       <= 1'b0;
            h_clear_q      <= 1'b0;
            h_x_address_q  <= '0;
            h_y_address_q  <= '0;
            h_pixel_q      <= 1'b0;
            x_median_q     <= '0;
            y_median_q     <= '0;
            pixel_count_q  <= '0;
            empty_q        <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sent_q         <= sent_d;
            guard_q        <= guard_d;
            x_q            <= x_d;
            y_q            <= y_d;
            acc_count_q    <= acc_count_d;
            sx_q           <= sx_d;
            sy_q           <= sy_d;
            xi_q           <= xi_d;
            yi_q           <= yi_d;
            x_hit_q        <= x_hit_d;
            y_hit_q        <= y_hit_d;
            x_cand_q       <= x_cand_d;
            y_cand_q       <= y_cand_d;
            pix_ready_q    <= pix_ready_d;
            h_start_q      <= h_start_d;
            h_stop_q       <= h_stop_d;
            h_read_q       <= h_read_d;
            h_clear_q      <= h_clear_d;
            h_x_address_q  <= h_x_address_d;
            h_y_address_q  <= h_y_address_d;
            h_pixel_q      <= h_pixel_d;
            x_median_q     <= x_median_d;
            y_median_q     <= y_median_d;
            pixel_count_q  <= pixel_count_d;
            empty_q        <= empty_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign pixReady    = pix_ready_q;
    assign hStart      = h_start_q;
    assign hStop       = h_stop_q;
    assign hRead       = h_read_q;
    assign hClear      = h_clear_q;
    assign hXAddress   = h_x_address_q;
    assign hYAddress   = h_y_address_q;
    assign hPixel      = h_pixel_q;
    assign xMedian     = x_median_q;
    assign yMedian     = y_median_q;
    assign pixelCount  = pixel_count_q;
    assign empty       = empty_q;
    assign resultValid = result_valid_q;
    assign busy        = busy_q;

endmodule
